// File: rtl/seg_pkg.sv
// Shared seven-segment constants and the segment vector type.
package seg_pkg;

  typedef logic [6:0] seg_t;  // seg[0]=a ... seg[6]=g, active-high

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD to seven-segment decoder; codes 10..15 show a dash.
module bcd_to_7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output seg_t       seg
);

  // Plain lookup; anything outside 0..9 is flagged visibly as a dash.
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed seven-segment scanner with per-frame digit snapshot.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module bcd_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [4*DIGITS-1:0]         bcd,
  input  logic                        en,
  output seg_t                        seg,
  output logic [DIGITS-1:0]           an,
  output logic [$clog2(DIGITS)-1:0]   digit_idx
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam logic [DIGITS-1:0] AN_ONE = DIGITS'(1);

  logic [PW-1:0]             pre;
  logic [DIGITS-1:0][3:0]    snap;
  logic                      tick;
  logic                      last_digit;
  seg_t                      dec;
  seg_t                      seg_next;

  assign tick       = (pre == PW'(PRESCALE - 1));
  assign last_digit = (digit_idx == IW'(DIGITS - 1));

  // Prescaler, digit rotation and frame-boundary snapshot of the digit bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre       <= '0;
      digit_idx <= '0;
      snap      <= '0;
    end else if (tick) begin
      pre       <= '0;
      digit_idx <= last_digit ? '0 : digit_idx + IW'(1);
      if (last_digit) snap <= bcd;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  bcd_to_7seg u_dec (
    .bcd (snap[digit_idx]),
    .seg (dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank;

  // blank[i]: digit i and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    blank = '0;
    blank[DIGITS-1] = (snap[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 1; i--)
      blank[i] = blank[i+1] && (snap[i] == 4'd0);
  end

  assign seg_next = blank[digit_idx] ? SEG_BLANK : dec;
`else
  assign seg_next = dec;
`endif

  // Registered drive; disabling only blanks, the scan keeps running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg <= SEG_BLANK;
      an  <= '0;
    end else if (en) begin
      seg <= seg_next;
      an  <= AN_ONE << digit_idx;
    end else begin
      seg <= SEG_BLANK;
      an  <= '0;
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display (DIGITS=4, PRESCALE=4).
module tb_bcd_scan_display;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ = 7'h00;
`else
  localparam logic [6:0] LZ = 7'h3F;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic [15:0] bcd = '0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] an;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bcd_scan_display #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .en        (en),
    .seg       (seg),
    .an        (an),
    .digit_idx (digit_idx)
  );

  task automatic push_digit(input logic [6:0] s, input logic [3:0] a, input int n);
    exp_t e;
    e.seg = s;
    e.an  = a;
    repeat (n) sb.push_back(e);
  endtask

  task automatic push_frame(input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3);
    push_digit(s0, 4'b0001, PRESCALE);
    push_digit(s1, 4'b0010, PRESCALE);
    push_digit(s2, 4'b0100, PRESCALE);
    push_digit(s3, 4'b1000, PRESCALE);
  endtask

  task automatic do_reset(input logic [15:0] v);
    @(negedge clk);
    bcd = v;
    en  = 1'b1;
    rst = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bcd = 16'h1234;
    en  = 1'b1;
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, digit_idx} !== {4'b0, 7'h00, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_async: an=%b seg=%h idx=%0d, want 0000/00/0", an, seg, digit_idx);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({an, seg, digit_idx} !== {4'b0, 7'h00, 2'd0}) begin
        n_bad++;
        $display("FAIL reset_hold%0d: an=%b seg=%h idx=%0d, want 0000/00/0", k, an, seg, digit_idx);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({an, seg, digit_idx} !== {4'b0001, 7'h3F, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_first: an=%b seg=%h idx=%0d, want 0001/3f/0", an, seg, digit_idx);
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (digit_idx !== 2'd0) begin
      n_bad++;
      $display("FAIL reset_idx3: idx=%0d, want 0", digit_idx);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (digit_idx !== 2'd1) begin
      n_bad++;
      $display("FAIL reset_idx4: idx=%0d, want 1", digit_idx);
    end
    // Mid-frame reset must clear everything without waiting for a clock.
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({an, seg, digit_idx} !== {4'b0, 7'h00, 2'd0}) begin
      n_bad++;
      $display("FAIL reset_midframe: an=%b seg=%h idx=%0d, want 0000/00/0", an, seg, digit_idx);
    end
  endtask

  task automatic test_scan();
    exp_t e;
    do_reset(16'h1234);
    push_frame(7'h3F, LZ, LZ, LZ);
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scan_empty cyc%0d: seg=%h an=%b, want queued entry", k, seg, an);
      end else begin
        e = sb.pop_front();
        if (seg !== e.seg || an !== e.an) begin
          n_bad++;
          $display("FAIL scan cyc%0d: seg=%h an=%b, want seg=%h an=%b", k, seg, an, e.seg, e.an);
        end
      end
    end
  endtask

  task automatic test_frame_atomic();
    exp_t e;
    do_reset(16'h1234);
    push_frame(7'h3F, LZ, LZ, LZ);
    push_frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    push_frame(7'h7F, 7'h07, 7'h7D, 7'h6D);
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL atomic_empty cyc%0d: seg=%h an=%b, want queued entry", k, seg, an);
      end else begin
        e = sb.pop_front();
        if (seg !== e.seg || an !== e.an) begin
          n_bad++;
          $display("FAIL atomic cyc%0d: seg=%h an=%b, want seg=%h an=%b", k, seg, an, e.seg, e.an);
        end
      end
      if (k == 22) begin
        n_cmp++;
        if (digit_idx !== 2'd1) begin
          n_bad++;
          $display("FAIL atomic_idx: idx=%0d, want 1", digit_idx);
        end
        bcd = 16'h5678;
      end
    end
  endtask

  task automatic test_invalid();
    exp_t e;
    do_reset(16'h00A0);
    push_frame(7'h3F, LZ, LZ, LZ);
    push_frame(7'h3F, 7'h40, LZ, LZ);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL invalid_empty cyc%0d: seg=%h an=%b, want queued entry", k, seg, an);
      end else begin
        e = sb.pop_front();
        if (seg !== e.seg || an !== e.an) begin
          n_bad++;
          $display("FAIL invalid cyc%0d: seg=%h an=%b, want seg=%h an=%b", k, seg, an, e.seg, e.an);
        end
      end
    end
  endtask

  task automatic test_enable();
    exp_t e;
    do_reset(16'h1234);
    push_frame(7'h3F, LZ, LZ, LZ);
    push_digit(7'h66, 4'b0001, 2);
    push_digit(7'h00, 4'b0000, 6);
    push_digit(7'h5B, 4'b0100, 4);
    push_digit(7'h06, 4'b1000, 4);
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL enable_empty cyc%0d: seg=%h an=%b, want queued entry", k, seg, an);
      end else begin
        e = sb.pop_front();
        if (seg !== e.seg || an !== e.an) begin
          n_bad++;
          $display("FAIL enable cyc%0d: seg=%h an=%b, want seg=%h an=%b", k, seg, an, e.seg, e.an);
        end
      end
      if (k == 18) en = 1'b0;
      if (k == 20) begin
        n_cmp++;
        if (digit_idx !== 2'd1) begin
          n_bad++;
          $display("FAIL enable_idx_low: idx=%0d, want 1", digit_idx);
        end
      end
      if (k == 24) begin
        n_cmp++;
        if (digit_idx !== 2'd2) begin
          n_bad++;
          $display("FAIL enable_idx_resume: idx=%0d, want 2", digit_idx);
        end
        en = 1'b1;
      end
    end
  endtask

  task automatic test_leading_zero();
    exp_t e;
    do_reset(16'h0007);
    push_frame(7'h3F, LZ, LZ, LZ);
    push_frame(7'h07, LZ, LZ, LZ);
    push_frame(7'h3F, LZ, LZ, LZ);
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL lz_empty cyc%0d: seg=%h an=%b, want queued entry", k, seg, an);
      end else begin
        e = sb.pop_front();
        if (seg !== e.seg || an !== e.an) begin
          n_bad++;
          $display("FAIL lz cyc%0d: seg=%h an=%b, want seg=%h an=%b", k, seg, an, e.seg, e.an);
        end
      end
      if (k == 20) bcd = 16'h0000;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want finish before 200000");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_scan();
    test_frame_atomic();
    test_invalid();
    test_enable();
    test_leading_zero();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed seven-segment driver that consumes the packed BCD digits produced by the decade counter chain and drives a common-anode-select, DIGITS-wide display. It sits directly downstream of the mod-10 counters. It snapshots the digit bus once per scan frame so a frame never mixes old and new digits, then rotates through the digits at a prescaled refresh rate.

## Interface
Parameters:
- DIGITS, default 4: number of display digits; must be ≥2.
- PRESCALE, default 1000: clk cycles each digit stays selected; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- bcd  in  4*DIGITS  packed BCD; digit i is bcd[4i+3:4i]; digit 0 is least significant.
- en  in  1  display enable; low blanks the outputs without stopping the scan.
- seg  out  7  segment drive, active-high; seg[0]=a … seg[6]=g.
- an  out  DIGITS  digit select, one-hot, active-high; an[i] selects digit i.
- digit_idx  out  clog2(DIGITS)  currently selected digit index.

## Operation
- Prescaler counts 0..PRESCALE-1 and wraps. The cycle with count==PRESCALE-1 is a tick. With PRESCALE=1, every cycle is a tick. Prescaler width is max(1, clog2(PRESCALE)).
- On a tick, digit_idx advances by 1, wrapping DIGITS-1 → 0.
- Frame snapshot: on a tick where digit_idx==DIGITS-1, the snapshot register loads bcd. Changes to bcd at any other time have no visible effect until the next frame boundary.
- Each cycle, seg and an are registered from the current digit_idx, the snapshot, and en:
  - en=1: an = one-hot(digit_idx); seg = decode(snapshot digit[digit_idx]).
  - en=0: an = 0, seg = 0. Prescaler and digit_idx keep running.
- Decode:
  - 0→0x3F, 1→0x06, 2→0x5B, 3→0x4F, 4→0x66, 5→0x6D, 6→0x7D, 7→0x07, 8→0x7F, 9→0x6F.
  - Codes 10..15 are invalid and display a dash, 0x40.
- Reset values (asserted asynchronously): prescaler 0, digit_idx 0, snapshot 0, seg 0x00, an 0.
- Reset asserted mid-frame aborts the scan immediately. There is no partial-frame recovery.

## Timing
- First rising edge after rst release: an=one-hot(0), seg=0x3F (snapshot is zero).
- Output latency: seg/an reflect a digit_idx change 1 cycle after the edge that changed it.
- Each digit is selected for exactly PRESCALE cycles. A full frame is DIGITS*PRESCALE cycles.
- A new bcd value appears on digit 0 no earlier than 1 cycle after the frame-boundary tick, and no later than one frame plus 1 cycle after bcd settles.
- en toggles take effect on seg/an after 1 cycle. digit_idx is unaffected by en.
- A tick on the same cycle that bcd changes captures the value present on that edge.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit i>0 shows seg=0x00 when the snapshot digit i and all higher snapshot digits are 0.
  - Digit 0 is never blanked.
  - an is still asserted for blanked digits.
  - Invalid codes count as non-zero.
- Not defined: every digit is decoded normally, so zeros show 0x3F.

## Structure
- Shared package seg_pkg holds:
  - SEG_0..SEG_9 constants, SEG_DASH (0x40) and SEG_BLANK (0x00).
  - A 7-bit seg_t typedef.
- One natural sub-module, bcd_to_7seg: 4-bit BCD in, seg_t out, purely combinational, includes the invalid-code dash. Top-level registers its output.
- Leading-zero mask is computed combinationally from the snapshot and kept inside the top level under the macro.

## Test plan
All scenarios use DIGITS=4, PRESCALE=4 unless stated.
- Reset:
  - Stimulus: hold rst low 3 cycles, release.
  - Required: while low, an=0000, seg=0x00, digit_idx=0. Next edge: an=0001, seg=0x3F. digit_idx reaches 1 after 4 cycles.
- Scan:
  - Stimulus: bcd=0x1234 from reset.
  - Required: first frame shows 0x3F on all digits. From the second frame, digits 0..3 show 0x66, 0x4F, 0x5B, 0x06 for 4 cycles each, with an=0001, 0010, 0100, 1000.
- Frame-atomic update:
  - Stimulus: change bcd 0x1234→0x5678 while digit_idx=1.
  - Required: digits 2 and 3 still show 0x5B and 0x06. The next frame shows 0x7F, 0x07, 0x7D, 0x6D.
- Invalid code:
  - Stimulus: bcd=0x00A0.
  - Required: digit 1 shows 0x40.
- Enable:
  - Stimulus: drop en for 6 cycles mid-frame.
  - Required: an=0 and seg=0 from the next cycle. digit_idx keeps advancing. Display resumes on the correct digit 1 cycle after en rises.
- Leading zeros:
  - Stimulus: bcd=0x0007, then 0x0000.
  - Required with LEADING_ZERO_BLANK_EN: digits 3..1 show seg=0x00, digit 0 shows 0x07, then 0x3F for 0x0000.
  - Required without the macro: digits 3..1 show 0x3F.
